pixel_threshold_counter: RTL and testbench

- Downstream consumer of the HPS-side bus exports: data_data[255:0] with datavalid_datavalid, data_trigger_export, a_export, b_export.
- Each 256-bit word carries 32 8-bit pixels. Words are buffered in a small FIFO and compared against a threshold, PIX_PER_CYCLE pixels per clock.
- Pixels strictly above threshold are counted over a frame of word_count words. Status and count are returned on ret_o, which drives ret_export.

---
 rtl/pixproc_pkg.sv | 28 ++
 rtl/word_fifo.sv | 69 ++++++
 rtl/pixel_threshold_counter.sv | 215 +++++++++++++++++++++
 tb/tb_pixel_threshold_counter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixproc_pkg
//  Description : Shared constants, FSM state type and ret_o field positions
//                for the pixel threshold counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixproc_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 256;
    localparam int PIX_PER_WORD = WORD_W / PIX_W;

    // Layout of the 32-bit status word returned to the host
    localparam int RET_W     = 32;
    localparam int DONE_BIT  = 31;
    localparam int OVF_BIT   = 30;
    localparam int BUSY_BIT  = 29;
    localparam int RET_CNT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : pixproc_pkg
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Synchronous FIFO with register-file storage, full/empty
//                flags and a synchronous flush. A push while full is taken
//                only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : word_fifo
`default_nettype wire

// File: rtl/pixel_threshold_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_threshold_counter
//  Description : Buffers 256-bit pixel words, serializes them PIX_PER_CYCLE
//                pixels per clock and counts pixels strictly above a
//                threshold over a frame of word_count words.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_threshold_counter
    import pixproc_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PIX_PER_CYCLE = 4,
    parameter int CNT_W         = 24
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [WORD_W-1:0] data_i,
    input  logic              datavalid_i,
    input  logic [31:0]       trigger_i,
    input  logic [PIX_W-1:0]  threshold_i,
    input  logic [15:0]       word_count_i,
    output logic [RET_W-1:0]  ret_o
);

    localparam int BEATS   = PIX_PER_WORD / PIX_PER_CYCLE;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int POP_W   = $clog2(PIX_PER_CYCLE + 1);
    localparam int SLICE_W = PIX_PER_CYCLE * PIX_W;

    // Control state
    state_e              state_q, state_d;
    logic                trig0_q;
    logic [PIX_W-1:0]    thr_q;
    logic [15:0]         wc_q;
    logic [15:0]         words_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    count_q;

    // Serializer
    logic [WORD_W-1:0]   ser_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                ser_vld_q;

    // Compare pipeline stage 1
    logic                s1_vld_q;
    logic [PIX_PER_CYCLE-1:0] hits_q;
    logic [POP_W-1:0]    pop_q;

    // Combinational control
    logic                start_edge;
    logic                abort;
    logic                start_go;
    logic                flush;
    logic                capture;
    logic                ovf_set;
    logic                ser_last;
    logic                ser_load;
    logic                frame_done;
    logic [PIX_PER_CYCLE-1:0] hits;
    logic [POP_W-1:0]    pop;
    logic [CNT_W:0]      cnt_sum;

    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rdata;

    // Upper trigger bits and the per-pixel hit vector are kept for debug only
    logic                unused_ok;
    assign unused_ok = ^{trigger_i[31:2], hits_q};

    assign start_edge = trigger_i[0] & ~trig0_q;
    assign abort      = trigger_i[1];
    // Abort outranks a simultaneous start; a start in RUN is not a restart
    assign start_go   = start_edge & ~abort & (state_q != RUN);
    assign flush      = abort | start_go;
    assign capture    = (state_q == RUN) & ~abort & datavalid_i & (words_q < wc_q);
    assign ser_last   = ser_vld_q & (beat_q == BEAT_W'(BEATS - 1));
    assign ser_load   = ~flush & ~fifo_empty & (~ser_vld_q | ser_last);
    // A word is lost only if the FIFO stays full after this cycle's pop
    assign ovf_set    = capture & fifo_full & ~ser_load;
    assign frame_done = (words_q == wc_q) & fifo_empty & ~ser_vld_q & ~s1_vld_q;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .flush_i (flush),
        .push_i  (capture),
        .pop_i   (ser_load),
        .wdata_i (data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: abort returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_edge) state_d = RUN;
                RUN:     if (frame_done) state_d = DONE;
                DONE:    if (start_edge) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and start-edge history
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            trig0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig0_q <= trigger_i[0];
        end
    end

    // Frame parameters, received-word count and sticky overflow
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            thr_q   <= '0;
            wc_q    <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else if (start_go) begin
            thr_q   <= threshold_i;
            wc_q    <= word_count_i;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (capture) words_q <= words_q + 16'd1;
            if (ovf_set) ovf_q   <= 1'b1;
        end
    end

    // Serializer: reload straight from the FIFO on the last beat to avoid bubbles
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ser_q     <= '0;
            beat_q    <= '0;
            ser_vld_q <= 1'b0;
        end else if (flush) begin
            beat_q    <= '0;
            ser_vld_q <= 1'b0;
        end else if (ser_load) begin
            ser_q     <= fifo_rdata;
            beat_q    <= '0;
            ser_vld_q <= 1'b1;
        end else if (ser_vld_q) begin
            if (ser_last) begin
                ser_vld_q <= 1'b0;
            end else begin
                ser_q  <= ser_q >> SLICE_W;
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Strict greater-than compare on the current beat's pixels
    for (genvar i = 0; i < PIX_PER_CYCLE; i++) begin : g_cmp
        assign hits[i] = (ser_q[i*PIX_W +: PIX_W] > thr_q);
    end

    // Popcount of the hit bits for this beat
    always_comb begin
        pop = '0;
        for (int i = 0; i < PIX_PER_CYCLE; i++) begin
            pop = pop + POP_W'(hits[i]);
        end
    end

    // Compare stage 1: register hit bits and their popcount
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_vld_q <= 1'b0;
            hits_q   <= '0;
            pop_q    <= '0;
        end else begin
            s1_vld_q <= ser_vld_q & ~flush;
            hits_q   <= hits;
            pop_q    <= pop;
        end
    end

    assign cnt_sum = {1'b0, count_q} + (CNT_W + 1)'(pop_q);

    // Compare stage 2: saturating accumulate; only a start clears the count
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            count_q <= '0;
        end else if (start_go) begin
            count_q <= '0;
        end else if (s1_vld_q) begin
            count_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    // Status word: flags from state/overflow, count zero-extended into 24 bits
    always_comb begin
        ret_o                       = '0;
        ret_o[DONE_BIT]             = (state_q == DONE);
        ret_o[OVF_BIT]              = ovf_q;
        ret_o[BUSY_BIT]             = (state_q == RUN);
        ret_o[RET_CNT_W-1:0]        = RET_CNT_W'(count_q);
    end

endmodule : pixel_threshold_counter
`default_nettype wire

// File: tb/tb_pixel_threshold_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_threshold_counter
//  Description : Self-checking bench for pixel_threshold_counter with a
//                pixel-counting reference model and randomized frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_threshold_counter;

    localparam int FIFO_DEPTH    = 4;
    localparam int PIX_PER_CYCLE = 4;
    localparam int CNT_W         = 24;

    localparam logic [31:0] DONE_F = 32'h8000_0000;
    localparam logic [31:0] OVF_F  = 32'h4000_0000;
    localparam logic [31:0] BUSY_F = 32'h2000_0000;

    logic         clk;
    logic         rst_n;
    logic [255:0] data;
    logic         dv;
    logic [31:0]  trig;
    logic [7:0]   thr;
    logic [15:0]  wc;
    logic [31:0]  ret;

    int n_pass;
    int n_total;

    pixel_threshold_counter #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PIX_PER_CYCLE (PIX_PER_CYCLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .data_i        (data),
        .datavalid_i   (dv),
        .trigger_i     (trig),
        .threshold_i   (thr),
        .word_count_i  (wc),
        .ret_o         (ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference: number of pixels strictly above the threshold in one word
    function automatic int count_above(input logic [255:0] w, input logic [7:0] t);
        int c = 0;
        for (int k = 0; k < 32; k++) begin
            if (w[8*k +: 8] > t) c++;
        end
        return c;
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom();
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] t, input logic [15:0] n);
        logic [31:0] r;
        r    = $urandom();
        thr  = t;
        wc   = n;
        trig = {r[31:2], 2'b01};
        tick();
        trig = {r[31:2], 2'b00};
    endtask

    task automatic send_word(input logic [255:0] w);
        data = w;
        dv   = 1'b1;
        tick();
        dv   = 1'b0;
        data = rand_word();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ret[31]) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if (ret !== 32'h0) $display("FAIL reset_ret got=%h required=%h", ret, 32'h0);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (ret !== 32'h0) $display("FAIL reset_idle got=%h required=%h", ret, 32'h0);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [255:0] w;
        int exp;
        w   = {256{1'b1}};
        exp = 2 * count_above(w, 8'h80);
        start_frame(8'h80, 16'd2);
        n_total++;
        if (ret !== BUSY_F) $display("FAIL basic_start got=%h required=%h", ret, BUSY_F);
        else n_pass++;
        send_word(w);
        repeat (40) tick();
        send_word(w);
        wait_done(100);
        n_total++;
        if (ret !== (DONE_F | 32'(exp))) $display("FAIL basic_done got=%h required=%h", ret, DONE_F | 32'(exp));
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [255:0] w;
        logic [7:0]   t_list [3];
        int           e_list [3];
        for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'(k);
        t_list = '{8'd15, 8'd31, 8'hFF};
        e_list = '{16, 0, 0};
        for (int i = 0; i < 3; i++) begin
            start_frame(t_list[i], 16'd1);
            send_word(w);
            wait_done(60);
            n_total++;
            if (ret !== (DONE_F | 32'(e_list[i])))
                $display("FAIL boundary_thr%0d got=%h required=%h", t_list[i], ret, DONE_F | 32'(e_list[i]));
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        // One word drains while four more fill the FIFO; the rest are lost
        start_frame(8'h00, 16'd8);
        for (int i = 0; i < 8; i++) send_word({256{1'b1}});
        wait_done(200);
        n_total++;
        if (ret !== (DONE_F | OVF_F | 32'd160))
            $display("FAIL overflow got=%h required=%h", ret, DONE_F | OVF_F | 32'd160);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        start_frame(8'h00, 16'd0);
        n_total++;
        if (ret !== BUSY_F) $display("FAIL zero_start got=%h required=%h", ret, BUSY_F);
        else n_pass++;
        wait_done(2);
        n_total++;
        if (ret !== DONE_F) $display("FAIL zero_done got=%h required=%h", ret, DONE_F);
        else n_pass++;
        for (int i = 0; i < 3; i++) send_word({256{1'b1}});
        repeat (20) tick();
        n_total++;
        if (ret !== DONE_F) $display("FAIL zero_ignore got=%h required=%h", ret, DONE_F);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [255:0] w;
        logic [7:0]   t;
        int exp;
        t   = 8'($urandom_range(0, 255));
        exp = 0;
        start_frame(t, 16'd4);
        for (int i = 0; i < 2; i++) begin
            w = rand_word();
            exp += count_above(w, t);
            send_word(w);
            repeat (15) tick();
        end
        repeat (20) tick();
        n_total++;
        if (ret !== (BUSY_F | 32'(exp))) $display("FAIL abort_partial got=%h required=%h", ret, BUSY_F | 32'(exp));
        else n_pass++;
        trig = 32'h0000_0002;
        tick();
        trig = 32'h0;
        n_total++;
        if (ret !== 32'(exp)) $display("FAIL abort_idle got=%h required=%h", ret, 32'(exp));
        else n_pass++;
        send_word({256{1'b1}});
        repeat (15) tick();
        n_total++;
        if (ret !== 32'(exp)) $display("FAIL abort_hold got=%h required=%h", ret, 32'(exp));
        else n_pass++;
        // Fresh frame after the abort
        t   = 8'($urandom_range(0, 255));
        exp = 0;
        start_frame(t, 16'd4);
        n_total++;
        if (ret !== BUSY_F) $display("FAIL abort_restart got=%h required=%h", ret, BUSY_F);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            w = rand_word();
            exp += count_above(w, t);
            send_word(w);
            repeat (9) tick();
        end
        wait_done(200);
        n_total++;
        if (ret !== (DONE_F | 32'(exp))) $display("FAIL abort_fresh got=%h required=%h", ret, DONE_F | 32'(exp));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [255:0] w;
        logic [7:0]   t;
        int n, exp;
        for (int it = 0; it < 8; it++) begin
            t   = 8'($urandom_range(0, 255));
            n   = $urandom_range(1, 5);
            exp = 0;
            start_frame(t, 16'(n));
            for (int i = 0; i < n; i++) begin
                w = rand_word();
                exp += count_above(w, t);
                send_word(w);
                repeat ($urandom_range(8, 15)) tick();
            end
            // Word beyond the frame length must be ignored
            send_word({256{1'b1}});
            wait_done(300);
            n_total++;
            if (ret !== (DONE_F | 32'(exp)))
                $display("FAIL random_%0d got=%h required=%h", it, ret, DONE_F | 32'(exp));
            else n_pass++;
        end
    endtask

    task automatic test_retrigger_reset();
        start_frame(8'h80, 16'd2);
        send_word({256{1'b1}});
        repeat (20) tick();
        send_word({256{1'b1}});
        wait_done(100);
        n_total++;
        if (ret !== (DONE_F | 32'd64)) $display("FAIL retrig_first got=%h required=%h", ret, DONE_F | 32'd64);
        else n_pass++;
        start_frame(8'h80, 16'd2);
        n_total++;
        if (ret !== BUSY_F) $display("FAIL retrig_clear got=%h required=%h", ret, BUSY_F);
        else n_pass++;
        send_word({256{1'b1}});
        repeat (3) tick();
        n_total++;
        if (ret[31:29] !== 3'b001) $display("FAIL retrig_busy got=%b required=%b", ret[31:29], 3'b001);
        else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ret !== 32'h0) $display("FAIL async_reset got=%h required=%h", ret, 32'h0);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_total++;
        if (ret !== 32'h0) $display("FAIL reset_release got=%h required=%h", ret, 32'h0);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        data    = '0;
        dv      = 1'b0;
        trig    = 32'h0;
        thr     = 8'h0;
        wc      = 16'h0;
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_zero_len();
        test_abort();
        test_random();
        test_retrigger_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pixel_threshold_counter
`default_nettype wire
